// File: rtl/lab82_dreg_bank.sv
// lab82_dreg_bank: bank of CHANNELS independent WIDTH-bit registers.
// One channel at a time is updated through a shared load / shift / invert
// datapath. Each channel keeps a saturating count of how often its value
// actually changed. CHG pulses for one cycle after every value-changing write.
module lab82_dreg_bank #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int CW       = 4,
    localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic                      CLR,
    input  logic [1:0]                MODE,
    input  logic [CHW-1:0]            CH,
    input  logic [WIDTH-1:0]          D,
    input  logic                      SI,
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic [WIDTH-1:0]          QSEL,
    output logic                      CHG,
    output logic [CW-1:0]             CNT
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    // Flattened views of every channel's value and counter, driven per channel.
    logic [CHANNELS*WIDTH-1:0] q_flat;
    logic [CHANNELS*CW-1:0]    cnt_flat;
    // One-hot decode of CH; all zero when CH names no existing channel.
    logic [CHANNELS-1:0]       ch_hit;

    logic [WIDTH-1:0] cur_val;
    logic [CW-1:0]    cur_cnt;
    logic             ch_valid;
    logic [WIDTH-1:0] new_val;
    logic             wr_change;
    logic             chg_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : gen_ch
            logic [WIDTH-1:0] val_reg;
            logic [CW-1:0]    cnt_reg;

            assign ch_hit[gi] = (CH == CHW'(gi));
            assign q_flat[gi*WIDTH +: WIDTH] = val_reg;
            assign cnt_flat[gi*CW +: CW]     = cnt_reg;

            // Channel storage: clear has priority; only a real value change
            // of this channel commits the new value and bumps its counter.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    val_reg <= '0;
                    cnt_reg <= '0;
                end else if (CLR) begin
                    val_reg <= '0;
                    cnt_reg <= '0;
                end else if (ch_hit[gi] && wr_change) begin
                    val_reg <= new_val;
                    if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end
        end
    endgenerate

    // Select the addressed channel's value and counter; zero if out of range.
    always_comb begin
        cur_val  = '0;
        cur_cnt  = '0;
        ch_valid = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_hit[k]) begin
                cur_val  = q_flat[k*WIDTH +: WIDTH];
                cur_cnt  = cnt_flat[k*CW +: CW];
                ch_valid = 1'b1;
            end
        end
    end

    // Shared update datapath and the "value really changes" decision.
    // CLR is not folded in here: it overrides everything at the registers.
    always_comb begin
        new_val = cur_val;
        case (MODE)
            2'b01:   new_val = D;
            2'b10:   new_val = {cur_val[WIDTH-2:0], SI};
            2'b11:   new_val = ~cur_val;
            default: new_val = cur_val;
        endcase
        wr_change = EN && ch_valid && (new_val != cur_val);
    end

    // One-cycle change pulse, suppressed by clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            chg_reg <= 1'b0;
        end else if (CLR) begin
            chg_reg <= 1'b0;
        end else begin
            chg_reg <= wr_change;
        end
    end

    assign Q    = q_flat;
    assign QSEL = cur_val;
    assign CNT  = cur_cnt;
    assign CHG  = chg_reg;

endmodule

// File: tb/tb_lab82_dreg_bank.sv
// Self-checking bench for lab82_dreg_bank (WIDTH=8, CHANNELS=4, CW=4).
// A behavioural model of the bank (plain arrays) predicts every output.
module tb_lab82_dreg_bank;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int CW       = 4;
    localparam int CHW      = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      en;
    logic                      clr;
    logic [1:0]                mode;
    logic [CHW-1:0]            ch;
    logic [WIDTH-1:0]          d;
    logic                      si;
    logic [CHANNELS*WIDTH-1:0] q;
    logic [WIDTH-1:0]          qsel;
    logic                      chg;
    logic [CW-1:0]             cnt;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model state
    int m_q   [CHANNELS];
    int m_cnt [CHANNELS];
    int m_chg;

    lab82_dreg_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CW(CW)) dut (
        .CLK (clk),
        .RST (rst),
        .EN  (en),
        .CLR (clr),
        .MODE(mode),
        .CH  (ch),
        .D   (d),
        .SI  (si),
        .Q   (q),
        .QSEL(qsel),
        .CHG (chg),
        .CNT (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_q_packed();
        logic [31:0] r = '0;
        for (int k = 0; k < CHANNELS; k++) r[k*8 +: 8] = 8'(m_q[k]);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < CHANNELS; k++) begin
            m_q[k]   = 0;
            m_cnt[k] = 0;
        end
        m_chg = 0;
    endtask

    // Behavioural update: what one edge does to the bank.
    task automatic model_edge();
        int c = int'(ch);
        int nv;
        if (clr) begin
            model_reset();
        end else if (en && c < CHANNELS) begin
            case (mode)
                2'd1:    nv = int'(d);
                2'd2:    nv = ((m_q[c] * 2) + int'(si)) % 256;
                2'd3:    nv = 255 - m_q[c];
                default: nv = m_q[c];
            endcase
            if (nv != m_q[c]) begin
                m_q[c]   = nv;
                m_cnt[c] = (m_cnt[c] < 15) ? m_cnt[c] + 1 : 15;
                m_chg    = 1;
            end else begin
                m_chg = 0;
            end
        end else begin
            m_chg = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        int c = int'(ch);
        chk({tag, "_q"},    32'(q),    model_q_packed());
        chk({tag, "_qsel"}, 32'(qsel), (c < CHANNELS) ? 32'(m_q[c]) : 32'd0);
        chk({tag, "_cnt"},  32'(cnt),  (c < CHANNELS) ? 32'(m_cnt[c]) : 32'd0);
        chk({tag, "_chg"},  32'(chg),  32'(m_chg));
    endtask

    // One transaction: drive inputs, take one edge, update model, check 1ns later.
    task automatic apply(input string tag, input logic c_en, input logic c_clr,
                         input logic [1:0] c_mode, input logic [CHW-1:0] c_ch,
                         input logic [WIDTH-1:0] c_d, input logic c_si);
        en = c_en; clr = c_clr; mode = c_mode; ch = c_ch; d = c_d; si = c_si;
        @(posedge clk);
        model_edge();
        #1;
        txn++;
        $display("txn %0d %s clr=%0b en=%0b mode=%0d ch=%0d d=%02h si=%0b -> q=%08h chg=%0b cnt=%0d",
                 txn, tag, c_clr, c_en, c_mode, c_ch, c_d, c_si, q, chg, cnt);
        check_outputs(tag);
    endtask

    // Look at one channel through QSEL/CNT without an edge.
    task automatic peek(input string tag, input logic [CHW-1:0] c_ch);
        en = 1'b0; clr = 1'b0; ch = c_ch;
        #1;
        chk({tag, "_qsel"}, 32'(qsel), 32'(m_q[int'(c_ch)]));
        chk({tag, "_cnt"},  32'(cnt),  32'(m_cnt[int'(c_ch)]));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'd0; ch = '0; d = '0; si = 1'b0;
        model_reset();
        #3;
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_chg", 32'(chg), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Load / select
        apply("ld_a5", 1'b1, 1'b0, 2'd1, 2'd2, 8'hA5, 1'b0);
        chk("ld_q_const", 32'(q), 32'h00A50000);
        chk("ld_qsel_const", 32'(qsel), 32'h000000A5);
        chk("ld_chg_const", 32'(chg), 32'd1);
        chk("ld_cnt_const", 32'(cnt), 32'd1);
        apply("ld_same", 1'b1, 1'b0, 2'd1, 2'd2, 8'hA5, 1'b0);
        chk("ld_same_chg", 32'(chg), 32'd0);
        chk("ld_same_cnt", 32'(cnt), 32'd1);

        // Shift and invert on channel 0
        apply("ld_81", 1'b1, 1'b0, 2'd1, 2'd0, 8'h81, 1'b0);
        apply("shl", 1'b1, 1'b0, 2'd2, 2'd0, 8'h00, 1'b1);
        chk("shl_qsel_const", 32'(qsel), 32'h03);
        apply("inv", 1'b1, 1'b0, 2'd3, 2'd0, 8'h00, 1'b0);
        chk("inv_qsel_const", 32'(qsel), 32'hFC);
        chk("inv_cnt_const", 32'(cnt), 32'd3);

        // Saturation on channel 1: every invert changes the value
        for (int i = 0; i < 20; i++) begin
            apply("sat", 1'b1, 1'b0, 2'd3, 2'd1, 8'h00, 1'b0);
            chk("sat_chg_const", 32'(chg), 32'd1);
        end
        chk("sat_cnt_const", 32'(cnt), 32'd15);

        // Isolation: loads to channel 3 leave others untouched
        apply("iso1", 1'b1, 1'b0, 2'd1, 2'd3, 8'h3C, 1'b0);
        apply("iso2", 1'b1, 1'b0, 2'd1, 2'd3, 8'hC3, 1'b0);
        for (int k = 0; k < 3; k++) peek("iso_peek", CHW'(k));

        // Ignored writes: EN=0 and MODE=00
        apply("en0", 1'b0, 1'b0, 2'd1, 2'd0, 8'h55, 1'b0);
        chk("en0_chg_const", 32'(chg), 32'd0);
        apply("hold", 1'b1, 1'b0, 2'd0, 2'd1, 8'h55, 1'b1);
        chk("hold_chg_const", 32'(chg), 32'd0);

        // Clear beats a simultaneous load
        apply("clr", 1'b1, 1'b1, 2'd1, 2'd2, 8'hFF, 1'b0);
        chk("clr_q_const", 32'(q), 32'd0);
        chk("clr_cnt_const", 32'(cnt), 32'd0);

        // Asynchronous reset mid-cycle after loads
        apply("pre_rst1", 1'b1, 1'b0, 2'd1, 2'd1, 8'h77, 1'b0);
        apply("pre_rst2", 1'b1, 1'b0, 2'd1, 2'd2, 8'h99, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_q", 32'(q), 32'd0);
        chk("arst_chg", 32'(chg), 32'd0);
        chk("arst_cnt", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        chk("arst_hold_q", 32'(q), 32'd0);
        rst = 1'b0;
        apply("post_rst", 1'b1, 1'b0, 2'd1, 2'd2, 8'h5A, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            apply("rnd",
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 29) == 0),
                  2'($urandom_range(0, 3)),
                  CHW'($urandom_range(0, CHANNELS - 1)),
                  8'($urandom),
                  1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lab82_dreg_bank.md
LAB82_DREG_BANK -- requirements
Module: lab82_dreg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per channel (legal range 2..32).
REQ-002 SHALL have parameter CHANNELS, default 4, meaning number of independent registers (legal range 2..16).
REQ-003 SHALL have parameter CW, default 4, meaning width of each per-channel change counter.
REQ-004 SHALL derive CHW = clog2(CHANNELS) (minimum 1) for channel-select width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, as decided for this block.
REQ-006 SHALL have port CLK  input  1  rising-edge clock.
REQ-007 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port EN  input  1  write enable for the selected channel.
REQ-009 SHALL have port CLR  input  1  synchronous clear of all channels and counters.
REQ-010 SHALL have port MODE  input  2  update mode: 00 hold, 01 load D, 10 shift-left with SI, 11 invert.
REQ-011 SHALL have port CH  input  CHW  channel select.
REQ-012 SHALL have port D  input  WIDTH  parallel load data.
REQ-013 SHALL have port SI  input  1  serial input for shift mode.
REQ-014 SHALL have port Q  output  CHANNELS*WIDTH  all channel registers; channel k at bits [k*WIDTH +: WIDTH].
REQ-015 SHALL have port QSEL  output  WIDTH  combinational view of channel CH.
REQ-016 SHALL have port CHG  output  1  registered pulse flagging a value-changing update.
REQ-017 SHALL have port CNT  output  CW  combinational view of the change counter of channel CH.

Function
REQ-018 SHALL update only at the rising CLK edge; no latch or level-transparent storage.
REQ-019 SHALL, when CLR=1 at an edge, set every channel register and counter to 0 and CHG to 0, regardless of EN, MODE or CH.
REQ-020 SHALL, when CLR=0 and EN=1 and CH<CHANNELS, compute the next value of channel CH from MODE: 00 unchanged; 01 D; 10 {Q_ch[WIDTH-2:0], SI}; 11 ~Q_ch.
REQ-021 SHALL leave all unselected channels unchanged on every edge where CLR=0.
REQ-022 SHALL ignore writes with EN=0 or CH>=CHANNELS: no register, counter or CHG change (CHG goes 0).
REQ-023 SHALL set CHG=1 for exactly the one cycle following an edge where the selected channel's new value differs from its old value, else CHG=0.
REQ-024 SHALL increment the selected channel's counter at the same edge when its value changes, saturating at 2^CW-1 (no wrap).
REQ-025 SHALL treat MODE=00 with EN=1 as a no-op: CHG=0, counter unchanged.
REQ-026 SHALL drive QSEL and CNT to 0 when CH>=CHANNELS.
REQ-027 SHALL give write-to-Q latency of one edge; QSEL and CNT reflect the new value in the same cycle Q does.
REQ-028 SHALL allow back-to-back writes to the same or different channels on consecutive edges, each producing its own CHG decision.

Reset
REQ-029 SHALL, while RST=1, immediately force Q, all counters and CHG to 0, independent of CLK.
REQ-030 SHALL, on RST assertion mid-sequence, discard any write in progress; first update after release occurs at the first rising edge with RST=0.

Verification (WIDTH=8, CHANNELS=4, CW=4)
REQ-031 SHALL verify reset: RST pulse asynchronously mid-cycle after loads -> Q=0x00000000, CHG=0, CNT=0 without a clock edge.
REQ-032 SHALL verify load/select: EN=1, MODE=01, CH=2, D=0xA5 -> next cycle Q=0x00A50000, QSEL=0xA5 with CH=2, CHG=1, CNT=1; then repeat same load -> CHG=0, CNT stays 1.
REQ-033 SHALL verify shift and invert: channel 0 loaded 0x81, MODE=10 SI=1 -> 0x03; MODE=11 -> 0xFC; CNT(ch0)=3.
REQ-034 SHALL verify saturation: 20 consecutive invert writes to channel 1 -> CNT(ch1)=15 and stays 15; CHG=1 on every one of those cycles.
REQ-035 SHALL verify priority and ignores: CLR=1 with EN=1, MODE=01, D=0xFF -> all Q=0, CNT=0; EN=0 or MODE=00 writes -> no change, CHG=0.
REQ-036 SHALL verify isolation: loads to channel 3 leave channels 0-2 and their counters unchanged.
